// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - code parameters shared by the convolutional encoder and the Viterbi decoder
package viterbi_pkg;

    localparam int       K_DEF  = 3;
    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;

    typedef enum logic {
        ENC_DATA,
        ENC_FLUSH
    } enc_state_t;

endpackage

// File: rtl/conv_parity.sv
// rtl/conv_parity.sv - generator parity for one encoder window, returns {c0, c1}
module conv_parity #(
    parameter int K = 3
) (
    input  logic [K-1:0] w,
    input  logic [K-1:0] g0,
    input  logic [K-1:0] g1,
    output logic [1:0]   pair
);

    assign pair = {^(w & g0), ^(w & g1)};

endmodule

// File: rtl/conv_encoder_k3.sv
// rtl/conv_encoder_k3.sv - rate-1/2 zero-terminated convolutional encoder with a one-deep output stage
module conv_encoder_k3
    import viterbi_pkg::*;
#(
    parameter int           K     = K_DEF,
    parameter logic [K-1:0] G0    = G0_DEF,
    parameter logic [K-1:0] G1    = G1_DEF,
    parameter int           CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [1:0]       tx_pair,
    output logic             tx_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int TAIL_W = 3;

    enc_state_t        state;
    logic [K-2:0]      sr;
    logic [TAIL_W-1:0] tail_cnt;
    logic              free;
    logic              enc;
    logic              b;
    logic              last_tail;
    logic [K-1:0]      w;
    logic [1:0]        pair;

    assign free      = !tx_valid || tx_ready;
    assign in_ready  = (state == ENC_DATA) && free;
    // In FLUSH the encoder feeds zeros whenever the output stage can take a pair.
    assign enc       = (state == ENC_DATA) ? (in_valid && free) : free;
    assign b         = (state == ENC_DATA) ? in_bit : 1'b0;
    assign w         = {sr, b};
    assign last_tail = (state == ENC_FLUSH) && (tail_cnt == TAIL_W'(K - 2));

    conv_parity #(.K(K)) u_parity (
        .w    (w),
        .g0   (G0),
        .g1   (G1),
        .pair (pair)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENC_DATA;
            sr        <= '0;
            tail_cnt  <= '0;
            tx_valid  <= 1'b0;
            tx_pair   <= 2'b00;
            tx_last   <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (enc) begin
                sr       <= {sr[K-3:0], b};
                tx_pair  <= pair;
                tx_last  <= last_tail;
                tx_valid <= 1'b1;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end

            if (tx_valid && tx_ready && tx_last) begin
                busy      <= 1'b0;
                frame_cnt <= frame_cnt + 1'b1;
            end

            // A new frame accepted in the same cycle as the previous tx_last keeps busy set.
            case (state)
                ENC_DATA: begin
                    if (enc) begin
                        busy <= 1'b1;
                        if (in_last) begin
                            state    <= ENC_FLUSH;
                            tail_cnt <= '0;
                        end
                    end
                end
                ENC_FLUSH: begin
                    if (enc) begin
                        if (last_tail) begin
                            state <= ENC_DATA;
                        end else begin
                            tail_cnt <= tail_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ENC_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// tb/tb_conv_encoder_k3.sv - vector table and scoreboard bench for conv_encoder_k3
module tb_conv_encoder_k3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        in_last;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  tx_pair;
    logic        tx_last;
    logic        busy;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    conv_encoder_k3 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_pair   (tx_pair),
        .tx_last   (tx_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [7:0]  bits;
        int          len;
        logic [15:0] exp;
        int          np;
        int          mode;
        bit          drain;
    } vec_t;

    vec_t       vecs[5];
    logic [2:0] sb[$];
    logic [2:0] got[$];
    bit         fbits[$];
    logic [1:0] m_sr;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         mode = 0;
    int         exp_frames = 0;
    bit         prev_stall = 0;
    logic [2:0] prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_pair(input logic [1:0] s, input logic bb);
        return {bb ^ s[0] ^ s[1], bb ^ s[1]};
    endfunction

    task automatic model_push(input logic bb, input logic lst);
        sb.push_back({1'b0, model_pair(m_sr, bb)});
        m_sr = {m_sr[0], bb};
        if (lst) begin
            for (int t = 0; t < 2; t++) begin
                sb.push_back({(t == 1) ? 1'b1 : 1'b0, model_pair(m_sr, 1'b0)});
                m_sr = {m_sr[0], 1'b0};
            end
        end
    endtask

    function automatic logic ready_for(input int m, input int c);
        case (m)
            0:       return 1'b1;
            1:       return (c % 3) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic tick(output bit hs);
        tx_ready = ready_for(mode, cyc);
        @(negedge clk);
        hs = 0;
        if (rst) begin
            sb.delete();
            m_sr       = 2'b00;
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check("stall_hold", {tx_valid, tx_last, tx_pair}, {1'b1, prev_out});
            if (tx_valid && tx_ready) begin
                got.push_back({tx_last, tx_pair});
                if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
                else check("sb_pair", {tx_last, tx_pair}, sb.pop_front());
            end
            if (tx_valid && !tx_ready)
                check("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                hs = 1;
                model_push(in_bit, in_last);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_out   = {tx_last, tx_pair};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_frame(input int m, input bit drain);
        int i     = 0;
        int guard = 0;
        bit hs;
        bit first = 1;
        mode = m;
        while (i < fbits.size() && guard < 5000) begin
            in_valid = (m == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (in_valid) begin
                in_bit  = fbits[i];
                in_last = (i == fbits.size() - 1);
            end else begin
                in_bit  = 1'($urandom_range(0, 1));
                in_last = 1'($urandom_range(0, 1));
            end
            tick(hs);
            if (hs) begin
                i++;
                if (first) check("busy_set", busy, 1);
                first = 0;
            end
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (guard >= 5000) check("in_timeout", i, fbits.size());
        exp_frames++;
        if (drain) begin
            guard = 0;
            while ((sb.size() != 0 || busy) && guard < 2000) begin
                in_bit  = 1'($urandom_range(0, 1));
                in_last = 1'($urandom_range(0, 1));
                tick(hs);
                guard++;
            end
            in_last = 1'b0;
            check("drain_timeout", guard < 2000, 1);
            check("busy_clear", busy, 0);
            check("frame_cnt", frame_cnt, exp_frames);
        end
    endtask

    initial begin
        bit         hs;
        int         idx;
        logic [2:0] e;

        vecs[0] = '{8'b1011_0000, 4, 16'b11_10_00_01_01_11_00_00, 6, 0, 1'b1};
        vecs[1] = '{8'b1000_0000, 1, 16'b11_10_11_00_00_00_00_00, 3, 0, 1'b1};
        vecs[2] = '{8'b1011_0000, 4, 16'b11_10_00_01_01_11_00_00, 6, 1, 1'b1};
        vecs[3] = '{8'b1100_0000, 2, 16'b11_01_01_11_00_00_00_00, 4, 0, 1'b0};
        vecs[4] = '{8'b0100_0000, 2, 16'b00_11_10_11_00_00_00_00, 4, 0, 1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
        tx_ready = 1'b1;
        m_sr     = 2'b00;
        prev_out = 3'b000;
        @(posedge clk);
        #1;
        tick(hs);
        tick(hs);
        rst = 1'b0;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_pair", tx_pair, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        got.delete();
        for (int v = 0; v < 5; v++) begin
            fbits.delete();
            for (int j = 0; j < vecs[v].len; j++) fbits.push_back(vecs[v].bits[7-j]);
            run_frame(vecs[v].mode, vecs[v].drain);
        end
        idx = 0;
        for (int v = 0; v < 5; v++) begin
            for (int p = 0; p < vecs[v].np; p++) begin
                e = {(p == vecs[v].np - 1) ? 1'b1 : 1'b0, vecs[v].exp[15-2*p -: 2]};
                if (idx < got.size()) check("vec_pair", got[idx], e);
                else check("vec_missing", idx, got.size());
                idx++;
            end
        end
        check("vec_count", got.size(), idx);

        // Reset in the middle of the flush, one tail pair already delivered.
        mode     = 0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_last  = 1'b1;
        tick(hs);
        check("flush_hs", hs, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick(hs);
        tick(hs);
        check("flush_busy", busy, 1);
        rst = 1'b1;
        tick(hs);
        rst = 1'b0;
        exp_frames = 0;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_frame_cnt", frame_cnt, 0);
        tick(hs);
        check("midrst_no_tail", tx_valid, 0);
        got.delete();
        fbits.delete();
        fbits.push_back(1'b1);
        run_frame(0, 1'b1);
        check("post_rst_count", got.size(), 3);
        if (got.size() > 0) check("post_rst_first", got[0], 3'b011);

        for (int f = 0; f < 10; f++) begin
            fbits.delete();
            for (int j = 0; j < int'($urandom_range(1, 200)); j++)
                fbits.push_back(1'($urandom_range(0, 1)));
            run_frame(2, 1'b1);
        end
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
